// File: rtl/ntt_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ntt_scheduler_if
// Description : Control bundle between the NTT job requester and the
//               ntt_scheduler sequencer.
//               Request side : start, mode_in, abort
//               Control side : mode_out, stage, grp, rd_en, wr_en, wr_stage,
//                              wr_grp, newloop, out_valid, busy, in_done,
//                              cal_done, done
//               master = job requester, slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface ntt_scheduler_if #(
    parameter int STAGE_W = 3,
    parameter int GRP_W   = 6
);
    logic               start;
    logic               mode_in;
    logic               abort;
    logic [1:0]         mode_out;
    logic [STAGE_W-1:0] stage;
    logic [GRP_W-1:0]   grp;
    logic               rd_en;
    logic               wr_en;
    logic [STAGE_W-1:0] wr_stage;
    logic [GRP_W-1:0]   wr_grp;
    logic               newloop;
    logic               out_valid;
    logic               busy;
    logic               in_done;
    logic               cal_done;
    logic               done;

    modport master (
        output start, mode_in, abort,
        input  mode_out, stage, grp, rd_en, wr_en, wr_stage, wr_grp,
        input  newloop, out_valid, busy, in_done, cal_done, done
    );

    modport slave (
        input  start, mode_in, abort,
        output mode_out, stage, grp, rd_en, wr_en, wr_stage, wr_grp,
        output newloop, out_valid, busy, in_done, cal_done, done
    );
endinterface
`default_nettype wire

// File: rtl/ntt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ntt_scheduler
// Description : Job sequencer for the 256-point NTT/INTT datapath. Each job
//               walks LOAD -> CALC (LOGN stages) -> UNLOAD -> DONE, issuing
//               read enables with stage/group indices and replaying them as
//               write enables after the memory / butterfly latency.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset
//               bus  - ntt_scheduler_if.slave (request in, control out)
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_scheduler #(
    parameter int LOGN     = 8,
    parameter int GRPS     = 64,
    parameter int ROM_LAT  = 1,
    parameter int RAM_LAT  = 1,
    parameter int PIPE_LAT = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ntt_scheduler_if.slave     bus
);

    localparam int c_cnt_w = $clog2(GRPS + PIPE_LAT + ROM_LAT + RAM_LAT + 1);
    localparam int c_grp_w = 6;
    localparam int c_stg_w = 3;

    localparam logic [c_cnt_w-1:0] c_grps      = c_cnt_w'(GRPS);
    localparam logic [c_cnt_w-1:0] c_load_last = c_cnt_w'(GRPS + ROM_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_calc_last = c_cnt_w'(GRPS + PIPE_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_unld_last = c_cnt_w'(GRPS + RAM_LAT - 1);
    localparam logic [c_stg_w-1:0] c_last_stg  = c_stg_w'(LOGN - 1);
    localparam logic [c_grp_w-1:0] c_last_grp  = c_grp_w'(GRPS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CALC   = 3'd2,
        S_UNLOAD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;       // cycle within the current phase/stage
    logic [c_stg_w-1:0]   r_stg;       // stages completed so far in CALC
    logic                 r_mode;      // 1 = INTT
    logic                 r_in_done;
    logic                 r_cal_done;

    logic                 w_flush;
    logic                 w_launch;
    logic                 w_phase_end;
    logic                 w_in_phase;
    logic                 w_issue;
    logic [c_stg_w-1:0]   w_stage_rd;

    // Delay lines: load (ROM), compute (RAM + butterfly), unload (RAM)
    logic                 r_lp_en  [ROM_LAT];
    logic [c_grp_w-1:0]   r_lp_grp [ROM_LAT];
    logic                 r_cp_en  [PIPE_LAT];
    logic [c_stg_w-1:0]   r_cp_stg [PIPE_LAT];
    logic [c_grp_w-1:0]   r_cp_grp [PIPE_LAT];
    logic                 r_up_en  [RAM_LAT];

    assign w_flush    = bus.abort && (r_state != S_IDLE);
    assign w_launch   = (r_state == S_IDLE) && bus.start && !bus.abort;
    assign w_in_phase = (r_state == S_LOAD) || (r_state == S_CALC) || (r_state == S_UNLOAD);
    assign w_issue    = w_in_phase && (r_cnt < c_grps);
    // INTT walks the stages from the top down
    assign w_stage_rd = r_mode ? (c_last_stg - r_stg) : r_stg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_cnt == c_load_last) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_calc_last) begin
                    w_phase_end = 1'b1;
                    if (r_stg == c_last_stg) begin
                        w_state_nxt = S_UNLOAD;
                    end
                end
            end
            S_UNLOAD: begin
                if (r_cnt == c_unld_last) begin
                    w_phase_end = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_stg      <= '0;
            r_mode     <= 1'b0;
            r_in_done  <= 1'b0;
            r_cal_done <= 1'b0;
        end else if (w_flush) begin
            r_cnt      <= '0;
            r_stg      <= '0;
            r_in_done  <= 1'b0;
            r_cal_done <= 1'b0;
        end else if (w_launch) begin
            r_mode     <= bus.mode_in;
            r_cnt      <= '0;
            r_stg      <= '0;
            r_in_done  <= 1'b0;
            r_cal_done <= 1'b0;
        end else if (w_in_phase) begin
            if (w_phase_end) begin
                r_cnt <= '0;
                if (r_state == S_LOAD) begin
                    r_in_done <= 1'b1;
                end
                if (r_state == S_CALC) begin
                    if (r_stg == c_last_stg) begin
                        r_cal_done <= 1'b1;
                        r_stg      <= '0;
                    end else begin
                        r_stg <= r_stg + 1'b1;
                    end
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Issue replay: writes land exactly the pipeline latency after the read,
    // so a stage's drain cycles cover its final write-backs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_lp_en[i]  <= 1'b0;
                r_lp_grp[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_cp_en[i]  <= 1'b0;
                r_cp_stg[i] <= '0;
                r_cp_grp[i] <= '0;
            end
            for (int i = 0; i < RAM_LAT; i++) begin
                r_up_en[i] <= 1'b0;
            end
        end else if (w_flush) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_lp_en[i]  <= 1'b0;
                r_lp_grp[i] <= '0;
            end
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_cp_en[i]  <= 1'b0;
                r_cp_stg[i] <= '0;
                r_cp_grp[i] <= '0;
            end
            for (int i = 0; i < RAM_LAT; i++) begin
                r_up_en[i] <= 1'b0;
            end
        end else begin
            r_lp_en[0]  <= w_issue && (r_state == S_LOAD);
            r_lp_grp[0] <= r_cnt[c_grp_w-1:0];
            for (int i = 1; i < ROM_LAT; i++) begin
                r_lp_en[i]  <= r_lp_en[i-1];
                r_lp_grp[i] <= r_lp_grp[i-1];
            end
            r_cp_en[0]  <= w_issue && (r_state == S_CALC);
            r_cp_stg[0] <= w_stage_rd;
            r_cp_grp[0] <= r_cnt[c_grp_w-1:0];
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_cp_en[i]  <= r_cp_en[i-1];
                r_cp_stg[i] <= r_cp_stg[i-1];
                r_cp_grp[i] <= r_cp_grp[i-1];
            end
            r_up_en[0] <= w_issue && (r_state == S_UNLOAD);
            for (int i = 1; i < RAM_LAT; i++) begin
                r_up_en[i] <= r_up_en[i-1];
            end
        end
    end

    always_comb begin
        bus.rd_en    = w_issue;
        bus.busy     = (r_state != S_IDLE);
        bus.done     = (r_state == S_DONE);
        bus.in_done  = r_in_done;
        bus.cal_done = r_cal_done;
        bus.newloop  = (r_state == S_CALC) && (r_cnt == '0);
        bus.mode_out = 2'b00;
        bus.stage    = '0;
        bus.grp      = '0;
        if (r_state == S_CALC) begin
            bus.mode_out = r_mode ? 2'b10 : 2'b01;
            bus.stage    = w_stage_rd;
        end
        // grp holds its last value through drain; it only wraps at a boundary
        if (w_in_phase) begin
            bus.grp = w_issue ? r_cnt[c_grp_w-1:0] : c_last_grp;
        end
        bus.wr_en     = r_lp_en[ROM_LAT-1] || r_cp_en[PIPE_LAT-1];
        bus.wr_grp    = '0;
        bus.wr_stage  = '0;
        if (r_lp_en[ROM_LAT-1]) begin
            bus.wr_grp = r_lp_grp[ROM_LAT-1];
        end else if (r_cp_en[PIPE_LAT-1]) begin
            bus.wr_grp   = r_cp_grp[PIPE_LAT-1];
            bus.wr_stage = r_cp_stg[PIPE_LAT-1];
        end
        bus.out_valid = r_up_en[RAM_LAT-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_scheduler
// Description : Self-checking bench for ntt_scheduler. A cycle-indexed
//               reference model derives every expected output from the job
//               timeline (load, per-stage issue/drain, unload, done).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_scheduler;

    localparam int G  = 64;   // issue cycles per phase/stage
    localparam int LN = 8;    // stages
    localparam int RL = 1;    // ROM latency
    localparam int ML = 1;    // RAM latency
    localparam int PL = 4;    // compute pipeline latency
    localparam int SL = G + PL;               // cycles per compute stage
    localparam int T_CALC = 1 + G + RL;       // first CALC cycle (66)
    localparam int T_UNLD = T_CALC + LN * SL; // first UNLOAD cycle (610)
    localparam int T_DONE = T_UNLD + G + ML;  // DONE cycle (675)

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   g_t = 0;

    ntt_scheduler_if sif ();

    ntt_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, g_t, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mode_out"},  32'(sif.mode_out),  0);
        chk({tag, ".stage"},     32'(sif.stage),     0);
        chk({tag, ".grp"},       32'(sif.grp),       0);
        chk({tag, ".rd_en"},     32'(sif.rd_en),     0);
        chk({tag, ".wr_en"},     32'(sif.wr_en),     0);
        chk({tag, ".wr_stage"},  32'(sif.wr_stage),  0);
        chk({tag, ".wr_grp"},    32'(sif.wr_grp),    0);
        chk({tag, ".newloop"},   32'(sif.newloop),   0);
        chk({tag, ".out_valid"}, 32'(sif.out_valid), 0);
        chk({tag, ".busy"},      32'(sif.busy),      0);
        chk({tag, ".in_done"},   32'(sif.in_done),   0);
        chk({tag, ".cal_done"},  32'(sif.cal_done),  0);
        chk({tag, ".done"},      32'(sif.done),      0);
    endtask

    // Expected outputs at cycle t of a job whose start was sampled at t=0.
    task automatic check_model(input int t, input logic m);
        int e_mode, e_stage, e_grp, e_rd, e_wr, e_wst, e_wgrp;
        int e_nl, e_ov, e_busy, e_ind, e_cald, e_done;
        int u, w;
        e_mode = 0; e_stage = 0; e_grp = 0; e_rd = 0; e_wr = 0; e_wst = 0;
        e_wgrp = 0; e_nl = 0; e_ov = 0;
        e_busy = (t >= 1 && t <= T_DONE) ? 1 : 0;
        e_ind  = (t >= T_CALC) ? 1 : 0;
        e_cald = (t >= T_UNLD) ? 1 : 0;
        e_done = (t == T_DONE) ? 1 : 0;
        if (t >= 1 && t < T_CALC) begin
            e_rd  = (t <= G) ? 1 : 0;
            e_grp = (t <= G) ? t - 1 : G - 1;
            if (t > RL) begin
                e_wr   = 1;
                e_wgrp = t - 1 - RL;
            end
        end else if (t >= T_CALC && t < T_UNLD) begin
            u       = t - T_CALC;
            e_mode  = m ? 2 : 1;
            e_stage = m ? (LN - 1 - u / SL) : u / SL;
            e_rd    = (u % SL < G) ? 1 : 0;
            e_grp   = (u % SL < G) ? u % SL : G - 1;
            e_nl    = (u % SL == 0) ? 1 : 0;
            w = u - PL;
            if (w >= 0 && (w % SL) < G) begin
                e_wr   = 1;
                e_wgrp = w % SL;
                e_wst  = m ? (LN - 1 - w / SL) : w / SL;
            end
        end else if (t >= T_UNLD && t < T_DONE) begin
            e_rd  = (t < T_UNLD + G) ? 1 : 0;
            e_grp = (t < T_UNLD + G) ? t - T_UNLD : G - 1;
            e_ov  = (t >= T_UNLD + ML) ? 1 : 0;
        end
        g_t = t;
        chk("mode_out",  32'(sif.mode_out),  32'(e_mode));
        chk("stage",     32'(sif.stage),     32'(e_stage));
        chk("grp",       32'(sif.grp),       32'(e_grp));
        chk("rd_en",     32'(sif.rd_en),     32'(e_rd));
        chk("wr_en",     32'(sif.wr_en),     32'(e_wr));
        chk("wr_stage",  32'(sif.wr_stage),  32'(e_wst));
        chk("wr_grp",    32'(sif.wr_grp),    32'(e_wgrp));
        chk("newloop",   32'(sif.newloop),   32'(e_nl));
        chk("out_valid", 32'(sif.out_valid), 32'(e_ov));
        chk("busy",      32'(sif.busy),      32'(e_busy));
        chk("in_done",   32'(sif.in_done),   32'(e_ind));
        chk("cal_done",  32'(sif.cal_done),  32'(e_cald));
        chk("done",      32'(sif.done),      32'(e_done));
    endtask

    // Called in cycle 0 (IDLE). Runs through cycle stop_t. While busy, start
    // and mode_in are scrambled and must be ignored; hold keeps start high.
    task automatic run_job(input logic m, input int stop_t, input bit hold);
        sif.start   = 1'b1;
        sif.mode_in = m;
        for (int t = 1; t <= stop_t; t++) begin
            tick();
            if (t <= T_DONE) begin
                sif.start = hold ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                sif.start = hold;
            end
            sif.mode_in = 1'($urandom);
            check_model(t, m);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic m;
        sif.start   = 1'b0;
        sif.mode_in = 1'b0;
        sif.abort   = 1'b0;

        // Reset state
        #3;
        g_t = 0;
        chk_all_zero("reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        // NTT job with nominal timing
        run_job(1'b0, T_DONE + 1, 1'b0);

        // abort and start together in IDLE: no job
        sif.start = 1'b1;
        sif.abort = 1'b1;
        tick();
        sif.start = 1'b0;
        sif.abort = 1'b0;
        g_t = -1;
        chk("abort_start.busy",  32'(sif.busy),  0);
        chk("abort_start.rd_en", 32'(sif.rd_en), 0);
        tick();
        chk("abort_start.busy2", 32'(sif.busy),  0);

        // INTT job with start held high; the next job starts right after IDLE
        run_job(1'b1, T_DONE + 1, 1'b1);
        m = 1'($urandom);
        run_job(m, T_DONE + 1, 1'b0);

        // abort mid-CALC at cycle 300
        m = 1'($urandom);
        run_job(m, 300, 1'b0);
        sif.abort = 1'b1;
        tick();
        sif.abort = 1'b0;
        sif.start = 1'b0;
        g_t = 301;
        chk("abort.busy",     32'(sif.busy),     0);
        chk("abort.wr_en",    32'(sif.wr_en),    0);
        chk("abort.rd_en",    32'(sif.rd_en),    0);
        chk("abort.in_done",  32'(sif.in_done),  0);
        chk("abort.cal_done", 32'(sif.cal_done), 0);
        chk("abort.mode_out", 32'(sif.mode_out), 0);
        for (int i = 0; i < 700; i++) begin
            tick();
            g_t = 302 + i;
            chk("abort.no_done", 32'(sif.done), 0);
            chk("abort.idle",    32'(sif.busy), 0);
        end

        // asynchronous reset mid-job at cycle 100
        m = 1'($urandom);
        run_job(m, 100, 1'b0);
        #2;
        rst = 1'b0;
        sif.start = 1'b0;
        #1;
        g_t = 100;
        chk_all_zero("async_reset");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("after_reset");

        // clean job after reset
        m = 1'($urandom);
        run_job(m, T_DONE + 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
